// File: rtl/fft_frame_loader.sv
// fft_frame_loader: ping-pong buffer that gathers 8 complex samples per frame
// and presents each complete frame in parallel to an 8-point FFT.
module fft_frame_loader #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_real,
    input  logic [DATA_W-1:0] s_img,
    input  logic              s_last,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [DATA_W-1:0] x0_real,
    output logic [DATA_W-1:0] x1_real,
    output logic [DATA_W-1:0] x2_real,
    output logic [DATA_W-1:0] x3_real,
    output logic [DATA_W-1:0] x4_real,
    output logic [DATA_W-1:0] x5_real,
    output logic [DATA_W-1:0] x6_real,
    output logic [DATA_W-1:0] x7_real,
    output logic [DATA_W-1:0] x0_img,
    output logic [DATA_W-1:0] x1_img,
    output logic [DATA_W-1:0] x2_img,
    output logic [DATA_W-1:0] x3_img,
    output logic [DATA_W-1:0] x4_img,
    output logic [DATA_W-1:0] x5_img,
    output logic [DATA_W-1:0] x6_img,
    output logic [DATA_W-1:0] x7_img,
    output logic              sync_err,
    output logic [7:0]        frame_cnt
);
    logic [DATA_W-1:0] bank_re [2][8];
    logic [DATA_W-1:0] bank_im [2][8];
    logic [2:0]        wr_idx;
    logic              wr_bank;
    logic              rd_bank;
    logic [1:0]        full;
    logic              accept;
    logic              consume;

    assign s_ready     = ~full[wr_bank];
    assign frame_valid = full[rd_bank];
    assign accept      = s_valid & s_ready;
    assign consume     = frame_valid & frame_ready;

    assign x0_real = frame_valid ? bank_re[rd_bank][0] : '0;
    assign x1_real = frame_valid ? bank_re[rd_bank][1] : '0;
    assign x2_real = frame_valid ? bank_re[rd_bank][2] : '0;
    assign x3_real = frame_valid ? bank_re[rd_bank][3] : '0;
    assign x4_real = frame_valid ? bank_re[rd_bank][4] : '0;
    assign x5_real = frame_valid ? bank_re[rd_bank][5] : '0;
    assign x6_real = frame_valid ? bank_re[rd_bank][6] : '0;
    assign x7_real = frame_valid ? bank_re[rd_bank][7] : '0;
    assign x0_img  = frame_valid ? bank_im[rd_bank][0] : '0;
    assign x1_img  = frame_valid ? bank_im[rd_bank][1] : '0;
    assign x2_img  = frame_valid ? bank_im[rd_bank][2] : '0;
    assign x3_img  = frame_valid ? bank_im[rd_bank][3] : '0;
    assign x4_img  = frame_valid ? bank_im[rd_bank][4] : '0;
    assign x5_img  = frame_valid ? bank_im[rd_bank][5] : '0;
    assign x6_img  = frame_valid ? bank_im[rd_bank][6] : '0;
    assign x7_img  = frame_valid ? bank_im[rd_bank][7] : '0;

    // A write bank is never full while accepting, so fill and drain always touch different banks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_idx    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= '0;
            frame_cnt <= '0;
            sync_err  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 8; k++) begin
                    bank_re[b][k] <= '0;
                    bank_im[b][k] <= '0;
                end
            end
        end else begin
            sync_err <= 1'b0;
            if (accept) begin
                bank_re[wr_bank][wr_idx] <= s_real;
                bank_im[wr_bank][wr_idx] <= s_img;
                if (wr_idx == 3'd7) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_idx        <= '0;
                    sync_err      <= ~s_last;
                end else if (s_last) begin
                    wr_idx   <= '0;
                    sync_err <= 1'b1;
                end else begin
                    wr_idx <= wr_idx + 3'd1;
                end
            end
            if (consume) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
                frame_cnt     <= frame_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: scoreboard bench; expected frames are queued as samples are accepted.
module tb_fft_frame_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_real = '0;
    logic [7:0] s_img = '0;
    logic       s_last = 1'b0;
    logic       frame_valid;
    logic       frame_ready = 1'b0;
    logic [7:0] x0_real, x1_real, x2_real, x3_real, x4_real, x5_real, x6_real, x7_real;
    logic [7:0] x0_img, x1_img, x2_img, x3_img, x4_img, x5_img, x6_img, x7_img;
    logic       sync_err;
    logic [7:0] frame_cnt;
    logic [127:0] xv;
    logic [127:0] q[$];
    logic [127:0] m_frame = '0;
    logic [127:0] basic_exp;
    int         m_idx = 0;
    logic [7:0] m_cnt = '0;
    logic       exp_sync = 1'b0;
    int         chk_cnt = 0;
    int         pass_cnt = 0;

    fft_frame_loader #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_img(s_img), .s_last(s_last),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .x0_real(x0_real), .x1_real(x1_real), .x2_real(x2_real), .x3_real(x3_real),
        .x4_real(x4_real), .x5_real(x5_real), .x6_real(x6_real), .x7_real(x7_real),
        .x0_img(x0_img), .x1_img(x1_img), .x2_img(x2_img), .x3_img(x3_img),
        .x4_img(x4_img), .x5_img(x5_img), .x6_img(x6_img), .x7_img(x7_img),
        .sync_err(sync_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    assign xv = {x7_img, x7_real, x6_img, x6_real, x5_img, x5_real, x4_img, x4_real,
                 x3_img, x3_real, x2_img, x2_real, x1_img, x1_real, x0_img, x0_real};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else pass_cnt++;
    endtask

    // Cycle-level model check; DUT outputs sampled mid-cycle, inputs change just after posedge.
    always @(negedge clk) begin
        check("valid", {127'd0, frame_valid}, {127'd0, q.size() != 0});
        check("ready", {127'd0, s_ready}, {127'd0, q.size() < 2});
        check("cnt", {120'd0, frame_cnt}, {120'd0, m_cnt});
        check("sync", {127'd0, sync_err}, {127'd0, exp_sync});
        exp_sync = 1'b0;
        if (!frame_valid) check("x_zero", xv, '0);
        if (frame_valid && q.size() != 0) check("x_frame", xv, q[0]);
        if (frame_valid && frame_ready && q.size() != 0) begin
            void'(q.pop_front());
            m_cnt++;
        end
    end

    task automatic send(input logic [7:0] re, input logic [7:0] im, input logic last);
        int n = 0;
        s_valid = 1'b1;
        s_real  = re;
        s_img   = im;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) begin
            check("send_timeout", 0, 1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_frame[m_idx*16 +: 16] = {im, re};
        if (m_idx == 7) begin
            q.push_back(m_frame);
            m_idx = 0;
            exp_sync = !last;
        end else if (last) begin
            m_idx = 0;
            exp_sync = 1'b1;
        end else begin
            m_idx++;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_idx = 0;
        m_cnt = '0;
        exp_sync = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", {127'd0, frame_valid}, 0);
        check("rst_ready", {127'd0, s_ready}, 1);
        check("rst_cnt", {120'd0, frame_cnt}, 0);
        check("rst_x", xv, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_valid", {127'd0, frame_valid}, 0);
        check("post_rst_ready", {127'd0, s_ready}, 1);
        cycles(1);
    endtask

    initial begin
        do_reset();
        // basic frame (k, -k)
        basic_exp = '0;
        for (int k = 0; k < 8; k++) begin
            send(8'(k), 8'(-k), k == 7);
            basic_exp[k*16 +: 16] = {8'(-k), 8'(k)};
        end
        @(negedge clk);
        check("basic_valid", {127'd0, frame_valid}, 1);
        check("basic_x", xv, basic_exp);
        check("basic_cnt", {120'd0, frame_cnt}, 0);
        cycles(3);
        @(negedge clk);
        check("basic_hold", xv, basic_exp);
        cycles(1);
        frame_ready = 1'b1;
        cycles(1);
        frame_ready = 1'b0;
        cycles(2);
        // backpressure: 16 fill both banks, 17th waits for one consume
        for (int k = 0; k < 16; k++) send(8'(k + 16), 8'(k + 100), k % 8 == 7);
        @(negedge clk);
        check("bp_ready", {127'd0, s_ready}, 0);
        cycles(1);
        fork
            send(8'h55, 8'hAA, 1'b0);
            begin
                cycles(4);
                frame_ready = 1'b1;
                cycles(1);
                frame_ready = 1'b0;
            end
        join
        cycles(2);
        frame_ready = 1'b1;
        cycles(3);
        // streaming
        do_reset();
        frame_ready = 1'b1;
        for (int k = 0; k < 64; k++) send(8'($urandom), 8'($urandom), k % 8 == 7);
        cycles(3);
        check("stream_cnt", {120'd0, frame_cnt}, 8);
        for (int k = 0; k < 248 * 8; k++) send(8'($urandom), 8'($urandom), k % 8 == 7);
        cycles(3);
        check("cnt_wrap", {120'd0, frame_cnt}, 0);
        // early s_last on the 5th sample, then a good frame
        frame_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(8'(k + 1), 8'(k + 2), k == 4);
        cycles(2);
        check("early_no_frame", {127'd0, frame_valid}, 0);
        for (int k = 0; k < 8; k++) send(8'(k * 3), 8'(k * 5), k == 7);
        frame_ready = 1'b1;
        cycles(3);
        // missing s_last
        frame_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(8'(200 + k), 8'(k), 1'b0);
        @(negedge clk);
        check("miss_sync", {127'd0, sync_err}, 1);
        check("miss_valid", {127'd0, frame_valid}, 1);
        frame_ready = 1'b1;
        cycles(3);
        // reset mid-operation
        frame_ready = 1'b0;
        for (int k = 0; k < 11; k++) send(8'(k + 7), 8'(k + 9), k == 7);
        do_reset();
        check("rst_mid_valid", {127'd0, frame_valid}, 0);
        for (int k = 0; k < 7; k++) send(8'(k), 8'(k), 1'b0);
        cycles(2);
        check("rst_mid_partial", {127'd0, frame_valid}, 0);
        send(8'd70, 8'd71, 1'b1);
        frame_ready = 1'b1;
        cycles(4);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/fft_frame_loader.md
FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, sample component width in bits (two's complement).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port s_valid  input  1  upstream sample valid.
REQ-005 SHALL have port s_ready  output  1  loader can accept a sample this cycle.
REQ-006 SHALL have port s_real  input  DATA_W  sample real part.
REQ-007 SHALL have port s_img  input  DATA_W  sample imaginary part.
REQ-008 SHALL have port s_last  input  1  upstream marks the sample as the final (8th) sample of a frame.
REQ-009 SHALL have port frame_valid  output  1  a complete 8-sample frame is presented to the FFT.
REQ-010 SHALL have port frame_ready  input  1  FFT consumes the presented frame this cycle.
REQ-011 SHALL have ports x0_real..x7_real  output  DATA_W each  frame sample k real part, natural order.
REQ-012 SHALL have ports x0_img..x7_img  output  DATA_W each  frame sample k imaginary part, natural order.
REQ-013 SHALL have port sync_err  output  1  one-cycle pulse on s_last/count mismatch.
REQ-014 SHALL have port frame_cnt  output  8  count of frames delivered (frame_valid & frame_ready).

Function
REQ-015 SHALL hold two 8-entry complex banks (ping-pong), a write index wr_idx (0..7), write bank wr_bank, read bank rd_bank and a full flag per bank.
REQ-016 SHALL drive s_ready = not full[wr_bank], combinationally from registered state only (no dependence on s_valid or frame_ready).
REQ-017 SHALL accept a sample when s_valid & s_ready: store it in bank[wr_bank][wr_idx], then increment wr_idx.
REQ-018 On acceptance with wr_idx = 7: SHALL set full[wr_bank], toggle wr_bank and clear wr_idx to 0.
REQ-019 On acceptance with s_last = 1 and wr_idx < 7: SHALL discard the partial frame, clear wr_idx to 0, leave full[wr_bank] clear, and pulse sync_err for one cycle.
REQ-020 On acceptance with wr_idx = 7 and s_last = 0: SHALL complete the frame normally and pulse sync_err for one cycle.
REQ-021 SHALL drive frame_valid = full[rd_bank].
REQ-022 While frame_valid = 1, x0..x7 SHALL equal bank[rd_bank] entries 0..7; while frame_valid = 0, x0..x7 SHALL be 0.
REQ-023 Outputs x0..x7 SHALL remain stable while frame_valid = 1 and frame_ready = 0.
REQ-024 On frame_valid & frame_ready: SHALL clear full[rd_bank], toggle rd_bank and increment frame_cnt, wrapping 255 -> 0.
REQ-025 Latency: frame_valid SHALL assert in the cycle after the 8th sample is accepted.
REQ-026 When a frame completes and a frame is consumed in the same cycle, both updates SHALL take effect.
REQ-027 With frame_ready held at 1, SHALL sustain one sample per cycle with s_ready never deasserting.
REQ-028 With both banks full, s_ready SHALL be 0, and no sample SHALL be stored or dropped.
REQ-029 frame_ready while frame_valid = 0 SHALL have no effect.

Reset
REQ-030 On rst = 0, asynchronously: wr_idx = 0; wr_bank = rd_bank = 0; both full flags = 0; all bank entries = 0; frame_cnt = 0; sync_err = 0.
REQ-031 During reset and in the first cycle after release, frame_valid = 0, x0..x7 = 0 and s_ready = 1.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame and all buffered frames; no frame SHALL be presented afterwards until 8 new samples are accepted.

Verification
REQ-033 Basic frame: after reset, send samples (k, -k) for k = 0..7, with s_last on k = 7 and frame_ready = 0 -> frame_valid = 1 in the next cycle; xk_real = k, xk_img = -k; frame_cnt = 0.
REQ-034 Backpressure: frame_ready = 0, send 16 samples, then a 17th -> s_ready = 0 after the 16th; the 17th is not accepted until one frame_ready pulse; the frames emerge in order (first 0..7, then 8..15).
REQ-035 Streaming: frame_ready = 1, 64 back-to-back samples -> s_ready is constantly 1; 8 frames delivered; frame_cnt = 8.
REQ-036 Early s_last: s_last on the 5th sample -> sync_err pulses for one cycle, no frame_valid, and the next 8 samples form a correct frame.
REQ-037 Missing s_last: 8 samples with s_last = 0 -> the frame is presented and sync_err pulses in the cycle after the 8th sample.
REQ-038 Reset mid-operation: one frame buffered plus 3 samples, then assert rst -> frame_valid = 0, s_ready = 1, frame_cnt = 0, and all x outputs = 0.
